// File: rtl/vec_collect.sv
// vec_collect
//   Framing stage ahead of the dot-product unit. Gathers a stream of
//   DATA_WIDTH_IN-bit samples, delimited by a start-of-vector flag, into an
//   N_IN-element vector and presents it in parallel with a one-cycle valid.
//   Truncated vectors and samples with no open vector are dropped and flagged.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_valid  sample strobe; i_sop / i_data are only looked at when high
//   i_sop    current sample is element 0 of a new vector
//   i_data   sample value
//   o_data   last completed vector, o_data[k] = k-th sample from SOP
//   o_valid  one-cycle pulse: o_data holds a newly completed vector
//   o_err    one-cycle pulse: truncated vector or orphan sample
//   o_busy   a vector is partially filled
module vec_collect #(
    parameter int DATA_WIDTH_IN = 16,
    parameter int N_IN          = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_sop,
    input  logic [DATA_WIDTH_IN-1:0] i_data,
    output logic [DATA_WIDTH_IN-1:0] o_data [N_IN],
    output logic                     o_valid,
    output logic                     o_err,
    output logic                     o_busy
);

    localparam int          CW   = $clog2(N_IN);
    localparam int unsigned NU   = N_IN;
    localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       count, count_n;
    logic [DATA_WIDTH_IN-1:0] fill [N_IN];

    logic                wr_en;
    logic [CW-1:0]       wr_idx;
    logic                complete;
    logic                flag_err;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_n  = state;
        count_n  = count;
        wr_en    = 1'b0;
        wr_idx   = '0;
        complete = 1'b0;
        flag_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_sop) begin
                        wr_en   = 1'b1;
                        count_n = CW'(1);
                        state_n = FILL;
                    end else begin
                        flag_err = 1'b1;
                    end
                end
            end
            FILL: begin
                if (i_valid) begin
                    if (i_sop) begin
                        // Truncation: restart the fill with this sample as element 0
                        flag_err = 1'b1;
                        wr_en    = 1'b1;
                        count_n  = CW'(1);
                    end else if (count == LAST) begin
                        complete = 1'b1;
                        count_n  = '0;
                        state_n  = IDLE;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = count;
                        count_n = count + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Fill buffer, output buffer and registered pulses.
    // The final sample goes straight into the output buffer, so the fill
    // buffer's last slot is never written and the whole vector lands atomically.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NU; k++) begin
                fill[k]   <= '0;
                o_data[k] <= '0;
            end
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_valid <= complete;
            o_err   <= flag_err;
            for (int unsigned k = 0; k < NU; k++) begin
                if (wr_en && wr_idx == CW'(k)) begin
                    fill[k] <= i_data;
                end
            end
            if (complete) begin
                for (int unsigned k = 0; k < NU - 1; k++) begin
                    o_data[k] <= fill[k];
                end
                o_data[N_IN-1] <= i_data;
            end
        end
    end

    assign o_busy = (state == FILL);

endmodule

// File: tb/tb_vec_collect.sv
// Testbench for vec_collect (DATA_WIDTH_IN=16, N_IN=8).
// Stimulus pushes expected pulses (kind, cycle, o_data) into a queue;
// a monitor on the falling edge pops and compares whenever o_valid/o_err rise.
module tb_vec_collect;

    localparam int W = 16;
    localparam int N = 8;

    typedef logic [W*N-1:0] vec_t;
    typedef struct {
        bit   is_err;
        int   exp_cyc;
        vec_t data;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         sop;
    logic [W-1:0] data;
    logic [W-1:0] odata [N];
    logic         ovalid;
    logic         oerr;
    logic         obusy;

    vec_collect #(.DATA_WIDTH_IN(W), .N_IN(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_sop   (sop),
        .i_data  (data),
        .o_data  (odata),
        .o_valid (ovalid),
        .o_err   (oerr),
        .o_busy  (obusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t q[$];
    int   total  = 0;
    int   passed = 0;
    vec_t hold_vec = '0;
    vec_t next_vec = '0;

    function automatic vec_t pack_out();
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = odata[i];
        return v;
    endfunction

    function automatic vec_t ramp(input logic [W-1:0] base);
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = base + W'(i);
        return v;
    endfunction

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // kind: 0 none, 1 sample completes a vector, 2 sample raises o_err
    task automatic drive(input bit v, input bit s, input logic [W-1:0] d,
                         input int kind, input int busy_exp);
        @(negedge clk);
        if (busy_exp >= 0) chk("busy", vec_t'(obusy), vec_t'(busy_exp));
        rst   = 1'b0;
        valid = v;
        sop   = s;
        data  = d;
        if (kind == 1) begin
            q.push_back('{1'b0, cyc + 1, next_vec});
            hold_vec = next_vec;
        end else if (kind == 2) begin
            q.push_back('{1'b1, cyc + 1, hold_vec});
        end
    endtask

    // Reset with a valid SOP sample presented, which must be ignored
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        sop   = 1'b1;
        data  = 16'hDEAD;
        repeat (ncyc - 1) @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        valid    = 1'b0;
        sop      = 1'b0;
        hold_vec = '0;
        chk("rst_data",  pack_out(),      '0);
        chk("rst_valid", vec_t'(ovalid),  '0);
        chk("rst_err",   vec_t'(oerr),    '0);
        chk("rst_busy",  vec_t'(obusy),   '0);
    endtask

    // Monitor
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (ovalid || oerr) begin
                chk("exclusive", vec_t'(ovalid & oerr), '0);
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_pulse: valid=%0b err=%0b, none expected (cycle %0d)",
                             ovalid, oerr, cyc);
                end else begin
                    r = q.pop_front();
                    chk("pulse_kind",  vec_t'(oerr), vec_t'(r.is_err));
                    chk("pulse_cycle", vec_t'(cyc),  vec_t'(r.exp_cyc));
                    chk(r.is_err ? "data_held" : "data", pack_out(), r.data);
                end
            end else if (q.size() > 0 && q[0].exp_cyc <= cyc) begin
                r = q.pop_front();
                total++;
                $display("FAIL missed_pulse: no pulse, expected %s at cycle %0d (now %0d)",
                         r.is_err ? "err" : "valid", r.exp_cyc, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps [7] = '{1, 0, 3, 2, 0, 1, 3};
        vec_t vb;
        rst   = 1'b1;
        valid = 1'b0;
        sop   = 1'b0;
        data  = '0;
        do_reset(2);

        // Orphan sample right after reset
        drive(1, 0, 16'h1234, 2, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Basic vector 1..8
        next_vec = ramp(16'd1);
        drive(1, 1, 16'd1, 0, 0);
        for (int i = 2; i <= 8; i++) drive(1, 0, W'(i), (i == 8) ? 1 : 0, 1);
        drive(0, 0, 0, 0, 0);

        // Gapped input 0x10..0x17
        next_vec = ramp(16'h0010);
        drive(1, 1, 16'h0010, 0, 0);
        for (int i = 1; i < 8; i++) begin
            repeat (gaps[i-1]) drive(0, 0, 0, 0, 1);
            drive(1, 0, 16'h0010 + W'(i), (i == 7) ? 1 : 0, 1);
        end
        drive(0, 0, 0, 0, 0);

        // Back-to-back vectors
        next_vec = ramp(16'd1);
        drive(1, 1, 16'd1, 0, 0);
        for (int i = 2; i <= 8; i++) drive(1, 0, W'(i), (i == 8) ? 1 : 0, 1);
        vb = '0;
        vb[0*W +: W] = 16'hFFFF;
        vb[7*W +: W] = 16'h8000;
        next_vec = vb;
        drive(1, 1, 16'hFFFF, 0, 0);
        for (int i = 1; i < 7; i++) drive(1, 0, 16'h0000, 0, 1);
        drive(1, 0, 16'h8000, 1, 1);
        drive(0, 0, 0, 0, 0);

        // SOP plus 4 samples, then reset mid-vector
        drive(1, 1, 16'h0051, 0, 0);
        for (int i = 2; i <= 5; i++) drive(1, 0, 16'h0050 + W'(i), 0, 1);
        do_reset(1);

        // Truncation: SOP plus 5, then SOP plus full vector 0xA0..0xA7
        drive(1, 1, 16'h0060, 0, 0);
        for (int i = 1; i <= 5; i++) drive(1, 0, 16'h0060 + W'(i), 0, 1);
        drive(1, 1, 16'h00A0, 2, 1);
        next_vec = ramp(16'h00A0);
        for (int i = 1; i < 8; i++) drive(1, 0, 16'h00A0 + W'(i), (i == 7) ? 1 : 0, 1);
        drive(0, 0, 0, 0, 0);

        // Normal vector after the truncation
        next_vec = ramp(16'h0030);
        drive(1, 1, 16'h0030, 0, 0);
        for (int i = 1; i < 8; i++) drive(1, 0, 16'h0030 + W'(i), (i == 7) ? 1 : 0, 1);

        repeat (4) drive(0, 0, 0, 0, -1);
        chk("data_final", pack_out(), ramp(16'h0030));
        chk("queue_empty", vec_t'(q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vec_collect.md
# vec_collect

Upstream framing stage for the dot-product unit. It collects a stream of DATA_WIDTH_IN-bit samples, one per valid cycle, into an N_IN-element vector. It then presents the whole vector in parallel with a single-cycle valid pulse, which is the vector/valid input contract of the dot-product unit. Vectors are delimited by a start-of-vector flag. Truncated vectors are discarded and flagged.

## Interface
Parameters:
- DATA_WIDTH_IN, 16, sample width in bits.
- N_IN, 8, samples per vector. Legal range is 2..256.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high. Clock is i_clk.
- i_valid  in  1  sample strobe. i_data/i_sop are sampled only when high.
- i_sop  in  1  marks the current sample as element 0 of a new vector.
- i_data  in  DATA_WIDTH_IN  sample value.
- o_data  out  DATA_WIDTH_IN x N_IN (unpacked array [N_IN])  last completed vector. o_data[k] is the k-th sample after and including SOP.
- o_valid  out  1  one-cycle pulse: o_data holds a newly completed vector.
- o_err  out  1  one-cycle pulse: a vector was truncated, or a sample arrived with no open vector.
- o_busy  out  1  high while a vector is partially filled.

## Operation
- Storage:
  - Fill buffer: N_IN x DATA_WIDTH_IN registers.
  - Output buffer: N_IN x DATA_WIDTH_IN registers, driving o_data.
  - Element counter: ceil(log2(N_IN)) bits.
- States:
  - IDLE: no vector open.
  - FILL: count samples stored, 1 <= count <= N_IN-1.
- IDLE:
  - i_valid & i_sop: store i_data in fill[0]. count <= 1. Go to FILL.
  - i_valid & !i_sop: drop the sample. Pulse o_err. Stay in IDLE.
  - !i_valid: hold.
- FILL:
  - !i_valid: hold. Gaps of any length are allowed; there is no timeout.
  - i_valid & !i_sop & count < N_IN-1: fill[count] <= i_data, count++.
  - i_valid & !i_sop & count == N_IN-1 (completion):
    - Output buffer <= {fill[0..N_IN-2], i_data}, loaded atomically in one cycle.
    - Pulse o_valid. count <= 0. Go to IDLE.
  - i_valid & i_sop (truncation):
    - Discard the partial vector. Pulse o_err.
    - fill[0] <= i_data, count <= 1. Stay in FILL.
    - The output buffer is not touched.
- The output buffer changes only on completion. It holds its value indefinitely otherwise, including across o_err events.
- Slots of the fill buffer not yet written in the current vector are never exposed on o_data.
- o_busy = (state == FILL).
- No arithmetic and no width change: samples pass through bit-exact.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: o_valid and the new o_data appear in the cycle after the last sample is accepted.
  - Example: the last sample is accepted at edge t; o_valid is high during cycle t+1 and for that cycle only.
- o_err is high during the cycle after the offending sample, for exactly one cycle.
- Back-to-back: an SOP in the cycle immediately after completion (state IDLE) is accepted. Sustained throughput is one vector per N_IN cycles with no bubble.
- o_valid and o_err are never high in the same cycle. Completion and truncation are mutually exclusive events on one sample.
- Reset values: o_data all zeros, o_valid 0, o_err 0, o_busy 0, state IDLE, count 0. The fill buffer is cleared to zero.
- Reset mid-vector: the partial vector is discarded with no o_err pulse. The first sample after reset must carry SOP.
- i_rst high overrides i_valid in the same cycle; that sample is dropped.

## Test plan
All scenarios use DATA_WIDTH_IN=16, N_IN=8.
- Basic vector: SOP plus 8 consecutive valid samples 1..8 -> one o_valid pulse one cycle after the 8th sample; o_data = {1,2,3,4,5,6,7,8}; o_err never high.
- Gapped input: samples 0x0010..0x0017 with 0-3 idle cycles of i_valid=0 between them -> o_valid only after the 8th sample; o_data = {0x10..0x17}; o_busy high from the cycle after the first sample until the cycle after the last.
- Back-to-back: two vectors {1..8} and {0xFFFF,0,0,0,0,0,0,0x8000} with no idle cycles -> o_valid pulses exactly 8 cycles apart; the second o_data matches bit-exactly.
- Truncation: SOP plus 5 samples, then SOP plus 8 samples 0xA0..0xA7 -> o_err pulse one cycle after the second SOP; one o_valid only, with o_data = {0xA0..0xA7`}; o_data is unchanged (zeros) during the truncation.
- Orphan sample and reset:
  - Valid sample without SOP right after reset -> o_err pulse, o_busy stays 0.
  - Later, SOP plus 4 samples, then i_rst -> all outputs return to zero.
  - A following full vector then completes normally.
